tl45_register_read: RTL and testbench
=====================================

# tl45_register_read

Operand-fetch stage of the TL45 pipeline, sitting between decode and the ALU stage. Reads the register file and resolves each source operand with forwarded values from the ALU and memory stages and the writeback port. It registers a complete ALU input bundle (opcode, destination, jump condition, two operand values, target offset, PC). It follows the same stall/flush handshake as the ALU stage and adds its own RAW-hazard stall when forwarding is compiled out.

## Interface
Parameters:
- none; widths are fixed by the shared package (32-bit data, 4-bit register index, 5-bit opcode).

Ports:
- i_clk  input  1  clock; everything is sampled on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_pipe_stall  input  1  downstream (ALU) stall; hold the output buffer.
- o_pipe_stall  output  1  stall to decode: i_pipe_stall OR local hazard stall.
- i_pipe_flush  input  1  flush from ALU (taken branch); clear the output buffer.
- o_pipe_flush  output  1  flush forwarded to decode; equals i_pipe_flush.
- i_opcode  input  5  decoded opcode; 0 = NOP.
- i_dr  input  4  destination register.
- i_sr1  input  4  source register index 1.
- i_sr2  input  4  source register index 2.
- i_imm  input  32  sign-extended immediate or branch offset.
- i_imm_valid  input  1  operand 2 is taken from i_imm instead of sr2.
- i_jmp_cond  input  4  branch condition code.
- i_pc  input  32  PC of this instruction.
- i_of1_reg  input  4  ALU-stage forward tag; 0 = none.
- i_of1_val  input  32  ALU-stage forward value.
- i_of2_reg  input  4  memory-stage forward tag; 0 = none.
- i_of2_val  input  32  memory-stage forward value.
- i_wb_reg  input  4  writeback destination; 0 = no write.
- i_wb_val  input  32  writeback data.
- o_opcode  output  5  registered opcode.
- o_dr  output  4  registered destination.
- o_jmp_cond  output  4  registered condition code.
- o_sr1_val  output  32  resolved operand 1.
- o_sr2_val  output  32  resolved operand 2, or the immediate.
- o_target_offset  output  32  registered i_imm.
- o_pc  output  32  registered PC.

## Operation
- Register file: r1–r15 are 32-bit registers. r0 reads as 0, and writes to r0 are discarded. r1–r15 are written when i_wb_reg != 0.
- Operand resolution, per source with index s, in priority order:
  - s == 0 gives 0.
  - s == i_of1_reg gives i_of1_val.
  - s == i_of2_reg gives i_of2_val.
  - s == i_wb_reg gives i_wb_val (same-cycle bypass).
  - Otherwise the register file value is used.
- Operand 2: when i_imm_valid is set, o_sr2_val = i_imm and sr2 is ignored for hazard checks.
- Buffer update, in priority order each edge:
  1. i_reset or i_pipe_flush: all outputs are cleared to 0, which is a NOP bubble.
  2. i_pipe_stall: all outputs hold.
  3. Local hazard stall: outputs are cleared to 0 (bubble inserted), and decode holds because o_pipe_stall is asserted.
  4. Otherwise all outputs load from the inputs and the resolved operands.
- Flush takes priority over every stall. The flushed instruction in decode is dropped by decode itself.
- The register-file write happens on every edge where i_wb_reg != 0, including during stall or flush. Reset clears all registers.

## Timing
- Latency: 1 cycle from decode inputs to the output buffer.
- Reset: every output is 0 on the edge after i_reset is sampled high, and all registers are 0.
- o_pipe_stall and o_pipe_flush are combinational, in the same cycle as their causes.
- A writeback and a read of the same register in the same cycle return the new value.
- A forward tag and a writeback to the same register in the same cycle: the forward tag wins, because it is the younger producer.
- Reset asserted mid-stall: reset wins, and the buffer clears.

## Configuration
- TL45_FORWARD_EN defined:
  - the i_of1 and i_of2 paths are used;
  - the local hazard stall is never raised.
- TL45_FORWARD_EN undefined:
  - the i_of1 and i_of2 values are ignored, and their tags are used only for hazard detection;
  - the local hazard stall is asserted while any needed nonzero source matches i_of1_reg or i_of2_reg;
  - the writeback bypass remains in both builds.

## Structure
- Shared package tl45_pkg holds:
  - the opcode localparams (NOP = 0, ADD = 1, SUB = 2, and so on, BR = 0x0C);
  - the register index and data width constants;
  - a reg_fwd_t struct {reg, val}.
- Sub-module tl45_register_file contains:
  - 15×32 storage;
  - two combinational read ports with write-through bypass;
  - one synchronous write port.
- Forward-mux and hazard logic stay in the top module.

## Test plan
- Reset, then read r1 and r2 without any writes: ADD r3,r1,r2 gives o_sr1_val = 0, o_sr2_val = 0, o_opcode = 1, o_dr = 3.
- Writeback r5 = 0xDEADBEEF while ADD r1,r5,r0 is issued in the same cycle: next cycle o_sr1_val = 0xDEADBEEF and o_sr2_val = 0.
- Forward priority: i_of1 = {r4, 0x11}, i_of2 = {r4, 0x22}, writeback {r4, 0x33}, with SUB r1,r4,r4: both operands are 0x11. Without the macro: o_pipe_stall = 1 and a zero bubble is output.
- i_pipe_stall held for 3 cycles while the inputs change: outputs keep their pre-stall values and o_pipe_stall = 1 throughout.
- i_pipe_flush asserted together with i_pipe_stall: next cycle all outputs are 0 and o_pipe_flush = 1 in the same cycle.
- BR with i_imm_valid, i_imm = 0x40, i_sr1 = r2 (r2 = 0x100), i_jmp_cond = 4: o_sr1_val = 0x100, o_target_offset = 0x40, o_sr2_val = 0x40, o_jmp_cond = 4.

Source files
------------

// File: rtl/tl45_pkg.sv
// TL45 shared definitions: opcodes, widths, forward tag/value pair, ALU input bundle.
// Latency: n/a (package only).
// Backpressure: n/a.
package tl45_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 4;
    localparam int OP_W     = 5;
    localparam int NUM_REGS = 16;

    localparam logic [OP_W-1:0] OP_NOP = 5'h00;
    localparam logic [OP_W-1:0] OP_ADD = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB = 5'h02;
    localparam logic [OP_W-1:0] OP_MUL = 5'h03;
    localparam logic [OP_W-1:0] OP_DIV = 5'h04;
    localparam logic [OP_W-1:0] OP_OR  = 5'h05;
    localparam logic [OP_W-1:0] OP_XOR = 5'h06;
    localparam logic [OP_W-1:0] OP_AND = 5'h07;
    localparam logic [OP_W-1:0] OP_NOT = 5'h08;
    localparam logic [OP_W-1:0] OP_SHL = 5'h09;
    localparam logic [OP_W-1:0] OP_SHR = 5'h0A;
    localparam logic [OP_W-1:0] OP_CMP = 5'h0B;
    localparam logic [OP_W-1:0] OP_BR  = 5'h0C;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   opcode_t;

    // Producer tag plus its value; idx 0 means "no producer".
    typedef struct packed {
        reg_idx_t idx;
        data_t    val;
    } reg_fwd_t;

    // Everything the ALU stage consumes; all-zero is a NOP bubble.
    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t dr;
        reg_idx_t jmp_cond;
        data_t    sr1_val;
        data_t    sr2_val;
        data_t    target_offset;
        data_t    pc;
    } alu_bundle_t;

    // True when source s is a real register produced by f.
    function automatic logic tag_hit(input reg_idx_t s, input reg_fwd_t f);
        return (s != '0) && (s == f.idx);
    endfunction

    // Younger producers win: ALU stage, then memory stage, then the register
    // file (which already carries the writeback bypass and the r0 rule).
    function automatic data_t fwd_sel(input reg_idx_t s, input data_t rf_val,
                                      input reg_fwd_t of1, input reg_fwd_t of2);
        if (s == '0)            return '0;
        else if (s == of1.idx)  return of1.val;
        else if (s == of2.idx)  return of2.val;
        else                    return rf_val;
    endfunction

endpackage

// File: rtl/tl45_register_file.sv
// TL45 register file: r1-r15 storage, r0 hardwired to zero, two async read ports.
// Latency: reads combinational with same-cycle write-through; write lands on the edge.
// Backpressure: none; the write port is accepted every cycle, even under stall/flush.
// Ports: i_clk/i_reset (sync, active-high, clears storage), i_rd1_idx/o_rd1_val,
//        i_rd2_idx/o_rd2_val read ports, i_wb write port (idx 0 = no write).
module tl45_register_file
    import tl45_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    input  reg_idx_t i_rd1_idx,
    output data_t    o_rd1_val,
    input  reg_idx_t i_rd2_idx,
    output data_t    o_rd2_val,
    input  reg_fwd_t i_wb
);

    data_t mem_q [1:NUM_REGS-1];
    data_t mem_d [1:NUM_REGS-1];

    always_comb begin
        mem_d = mem_q;
        if (i_wb.idx != '0) begin
            mem_d[i_wb.idx] = i_wb.val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // r0 check first so index 0 never reaches the storage array.
    assign o_rd1_val = (i_rd1_idx == '0)       ? '0 :
                       (i_rd1_idx == i_wb.idx) ? i_wb.val : mem_q[i_rd1_idx];
    assign o_rd2_val = (i_rd2_idx == '0)       ? '0 :
                       (i_rd2_idx == i_wb.idx) ? i_wb.val : mem_q[i_rd2_idx];

endmodule

// File: rtl/tl45_register_read.sv
// TL45 operand fetch: reads registers, resolves forwards, registers the ALU input bundle.
// Latency: 1 cycle decode -> output buffer; o_pipe_stall/o_pipe_flush are combinational.
// Backpressure: i_pipe_stall holds the buffer; a RAW hazard (forwarding off) inserts a bubble and stalls decode.
// Build option TL45_FORWARD_EN: when defined, ALU/memory forward values are muxed into
// the operands and no hazard stall exists; otherwise their tags only raise the hazard stall.
// Ports: pipeline control (i/o_pipe_stall, i/o_pipe_flush), decode inputs (i_opcode..i_pc),
//        forward ports (i_of1_*, i_of2_*), writeback port (i_wb_*), ALU bundle outputs (o_*).
module tl45_register_read
    import tl45_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_stall,
    output logic              o_pipe_stall,
    input  logic              i_pipe_flush,
    output logic              o_pipe_flush,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [REG_W-1:0]  i_dr,
    input  logic [REG_W-1:0]  i_sr1,
    input  logic [REG_W-1:0]  i_sr2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_imm_valid,
    input  logic [REG_W-1:0]  i_jmp_cond,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [REG_W-1:0]  i_of1_reg,
    input  logic [DATA_W-1:0] i_of1_val,
    input  logic [REG_W-1:0]  i_of2_reg,
    input  logic [DATA_W-1:0] i_of2_val,
    input  logic [REG_W-1:0]  i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_val,
    output logic [OP_W-1:0]   o_opcode,
    output logic [REG_W-1:0]  o_dr,
    output logic [REG_W-1:0]  o_jmp_cond,
    output logic [DATA_W-1:0] o_sr1_val,
    output logic [DATA_W-1:0] o_sr2_val,
    output logic [DATA_W-1:0] o_target_offset,
    output logic [DATA_W-1:0] o_pc
);

    reg_fwd_t    of1, of2, wb;
    data_t       rf_rd1, rf_rd2;
    data_t       sr1_val, sr2_val;
    logic        hazard;
    alu_bundle_t bundle_q, bundle_d;

    assign of1 = '{idx: i_of1_reg, val: i_of1_val};
    assign of2 = '{idx: i_of2_reg, val: i_of2_val};
    assign wb  = '{idx: i_wb_reg,  val: i_wb_val};

    tl45_register_file u_rf (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_rd1_idx (i_sr1),
        .o_rd1_val (rf_rd1),
        .i_rd2_idx (i_sr2),
        .o_rd2_val (rf_rd2),
        .i_wb      (wb)
    );

`ifdef TL45_FORWARD_EN
    always_comb begin
        sr1_val = fwd_sel(i_sr1, rf_rd1, of1, of2);
        sr2_val = i_imm_valid ? i_imm : fwd_sel(i_sr2, rf_rd2, of1, of2);
        hazard  = 1'b0;
    end
`else
    // Forward values are not wired in; their tags mark in-flight producers.
    logic unused_fwd_vals;
    assign unused_fwd_vals = ^{of1.val, of2.val};

    always_comb begin
        sr1_val = rf_rd1;
        sr2_val = i_imm_valid ? i_imm : rf_rd2;
        hazard  = tag_hit(i_sr1, of1) || tag_hit(i_sr1, of2) ||
                  (!i_imm_valid && (tag_hit(i_sr2, of1) || tag_hit(i_sr2, of2)));
    end
`endif

    assign o_pipe_stall = i_pipe_stall | hazard;
    assign o_pipe_flush = i_pipe_flush;

    // Flush beats downstream stall, which beats the local hazard bubble.
    always_comb begin
        bundle_d = bundle_q;
        if (i_pipe_flush) begin
            bundle_d = '0;
        end else if (i_pipe_stall) begin
            bundle_d = bundle_q;
        end else if (hazard) begin
            bundle_d = '0;
        end else begin
            bundle_d.opcode        = i_opcode;
            bundle_d.dr            = i_dr;
            bundle_d.jmp_cond      = i_jmp_cond;
            bundle_d.sr1_val       = sr1_val;
            bundle_d.sr2_val       = sr2_val;
            bundle_d.target_offset = i_imm;
            bundle_d.pc            = i_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign o_opcode        = bundle_q.opcode;
    assign o_dr            = bundle_q.dr;
    assign o_jmp_cond      = bundle_q.jmp_cond;
    assign o_sr1_val       = bundle_q.sr1_val;
    assign o_sr2_val       = bundle_q.sr2_val;
    assign o_target_offset = bundle_q.target_offset;
    assign o_pc            = bundle_q.pc;

endmodule

// File: tb/tb_tl45_register_read.sv
// Bench for tl45_register_read: directed pipeline scenarios then random traffic.
// Expected bundles are queued by the driver and popped by a monitor after each edge.
// Honors TL45_FORWARD_EN in the reference model.
module tb_tl45_register_read;

    logic        i_clk = 1'b0;
    logic        i_reset, i_pipe_stall, i_pipe_flush, i_imm_valid;
    logic        o_pipe_stall, o_pipe_flush;
    logic [4:0]  i_opcode, o_opcode;
    logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond, i_of1_reg, i_of2_reg, i_wb_reg;
    logic [3:0]  o_dr, o_jmp_cond;
    logic [31:0] i_imm, i_pc, i_of1_val, i_of2_val, i_wb_val;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

    tl45_register_read dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
        .i_pipe_flush(i_pipe_flush), .o_pipe_flush(o_pipe_flush),
        .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_imm(i_imm), .i_imm_valid(i_imm_valid), .i_jmp_cond(i_jmp_cond), .i_pc(i_pc),
        .i_of1_reg(i_of1_reg), .i_of1_val(i_of1_val),
        .i_of2_reg(i_of2_reg), .i_of2_val(i_of2_val),
        .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
        .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
        .o_target_offset(o_target_offset), .o_pc(o_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  dr;
        logic [3:0]  jc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] off;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        model_out;
    logic [31:0] regs [16];
    int          checks = 0;
    int          passed = 0;
    bit          drive_done = 0;

    `ifdef TL45_FORWARD_EN
    localparam bit FWD = 1'b1;
    `else
    localparam bit FWD = 1'b0;
    `endif

    // Architectural value a source sees this cycle.
    function automatic logic [31:0] operand(input logic [3:0] s);
        if (s == 0) return 32'd0;
        if (FWD && s == i_of1_reg) return i_of1_val;
        if (FWD && s == i_of2_reg) return i_of2_val;
        if (s == i_wb_reg) return i_wb_val;
        return regs[s];
    endfunction

    function automatic bit pending(input logic [3:0] s);
        return s != 0 && (s == i_of1_reg || s == i_of2_reg);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0b required=%0b at %0t", name, act, req, $time);
    endtask

    task automatic clr();
        {i_reset, i_pipe_stall, i_pipe_flush, i_imm_valid} = '0;
        {i_opcode, i_dr, i_sr1, i_sr2, i_jmp_cond} = '0;
        {i_of1_reg, i_of2_reg, i_wb_reg} = '0;
        {i_imm, i_pc, i_of1_val, i_of2_val, i_wb_val} = '0;
    endtask

    // Called in the low clock phase with inputs already set; advances one edge.
    task automatic cycle();
        bit   haz;
        exp_t nxt;
        #1;
        haz = !FWD && (pending(i_sr1) || (!i_imm_valid && pending(i_sr2)));
        check_bit("o_pipe_stall", o_pipe_stall, i_pipe_stall | haz);
        check_bit("o_pipe_flush", o_pipe_flush, i_pipe_flush);
        if (i_reset || i_pipe_flush) nxt = '0;
        else if (i_pipe_stall)       nxt = model_out;
        else if (haz)                nxt = '0;
        else nxt = '{op: i_opcode, dr: i_dr, jc: i_jmp_cond, s1: operand(i_sr1),
                     s2: i_imm_valid ? i_imm : operand(i_sr2), off: i_imm, pc: i_pc};
        model_out = nxt;
        exp_q.push_back(nxt);
        if (i_reset) for (int k = 0; k < 16; k++) regs[k] = 0;
        else if (i_wb_reg != 0) regs[i_wb_reg] = i_wb_val;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic instr(input logic [4:0] op, input logic [3:0] dr, s1, s2);
        i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2;
        i_pc = i_pc + 4;
    endtask

    // Monitor: the buffer is always presented, so one bundle is due per edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc};
                checks++;
                if (a === e) passed++;
                else $display("FAIL bundle: actual op=%h dr=%h jc=%h s1=%h s2=%h off=%h pc=%h required op=%h dr=%h jc=%h s1=%h s2=%h off=%h pc=%h",
                              a.op, a.dr, a.jc, a.s1, a.s2, a.off, a.pc,
                              e.op, e.dr, e.jc, e.s1, e.s2, e.off, e.pc);
            end
        end
    end

    initial begin
        model_out = '0;
        for (int k = 0; k < 16; k++) regs[k] = 0;
        clr();
        i_reset = 1'b1;
        i_wb_reg = 4'd7; i_wb_val = 32'h1234;   // reset must win over the write
        cycle();
        cycle();
        clr();

        // ADD r3,r1,r2 on a cleared file.
        instr(5'h01, 4'd3, 4'd1, 4'd2); cycle();
        // Same-cycle writeback of r5 read by ADD r1,r5,r0.
        instr(5'h01, 4'd1, 4'd5, 4'd0);
        i_wb_reg = 4'd5; i_wb_val = 32'hDEADBEEF; cycle();
        i_wb_reg = 0;
        // Forward priority / hazard on r4.
        instr(5'h02, 4'd1, 4'd4, 4'd4);
        i_of1_reg = 4'd4; i_of1_val = 32'h11;
        i_of2_reg = 4'd4; i_of2_val = 32'h22;
        i_wb_reg  = 4'd4; i_wb_val  = 32'h33; cycle();
        {i_of1_reg, i_of2_reg, i_wb_reg} = '0;
        // Load a value, then stall 3 cycles with changing inputs.
        instr(5'h01, 4'd6, 4'd5, 4'd4); cycle();
        i_pipe_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr(5'(k + 3), 4'(k + 7), 4'(k + 1), 4'(k + 2)); cycle();
        end
        // Flush together with stall.
        i_pipe_flush = 1'b1; cycle();
        i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;
        // Reset mid-stall after loading something.
        instr(5'h01, 4'd2, 4'd5, 4'd5); cycle();
        i_pipe_stall = 1'b1; i_reset = 1'b1; cycle();
        i_pipe_stall = 1'b0; i_reset = 1'b0;
        // r2 = 0x100, then BR with immediate.
        instr(5'h00, 4'd0, 4'd0, 4'd0);
        i_wb_reg = 4'd2; i_wb_val = 32'h100; cycle();
        i_wb_reg = 0;
        instr(5'h0C, 4'd0, 4'd2, 4'd9);
        i_imm_valid = 1'b1; i_imm = 32'h40; i_jmp_cond = 4'd4; cycle();
        clr();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            instr(5'($urandom_range(0, 12)), 4'($urandom), 4'($urandom), 4'($urandom));
            i_imm        = $urandom;
            i_imm_valid  = ($urandom_range(0, 3) == 0);
            i_jmp_cond   = 4'($urandom);
            i_pc         = $urandom;
            i_of1_reg    = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
            i_of1_val    = $urandom;
            i_of2_reg    = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
            i_of2_val    = $urandom;
            i_wb_reg     = $urandom_range(0, 4) != 0 ? 4'($urandom) : 4'd0;
            i_wb_val     = $urandom;
            i_pipe_stall = ($urandom_range(0, 4) == 0);
            i_pipe_flush = ($urandom_range(0, 11) == 0);
            i_reset      = ($urandom_range(0, 49) == 0);
            cycle();
        end
        clr();
        cycle();
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        drive_done = 1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Backstop so the run can never hang.
    initial begin
        #200000;
        if (!drive_done) begin
            $display("FAIL timeout: actual=running required=finished");
            $fatal(1, "timeout");
        end
    end

endmodule
